// File: rtl/mpu6050_burst_sequencer_if.sv
// Request/response bundle between the burst sequencer and the I2C master core.
// No latency of its own; it only groups the wires.
// Flow control is by level handshake: start/stop requests are held until the master acknowledges them.
//
// Signals:
//   i2c_start        sequencer -> master  start request (level)
//   i2c_stop         sequencer -> master  stop request (level)
//   i2c_reg_addr     sequencer -> master  register address (master data_in)
//   i2c_rd_data      master -> sequencer  received byte (master data_out)
//   i2c_avail_data   master -> sequencer  byte received (multi-cycle level)
//   i2c_avail_master master -> sequencer  1 = master idle
interface mpu6050_burst_sequencer_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic [7:0] i2c_reg_addr;
    logic [7:0] i2c_rd_data;
    logic       i2c_avail_data;
    logic       i2c_avail_master;

    modport master (
        output i2c_start,
        output i2c_stop,
        output i2c_reg_addr,
        input  i2c_rd_data,
        input  i2c_avail_data,
        input  i2c_avail_master
    );

    modport slave (
        input  i2c_start,
        input  i2c_stop,
        input  i2c_reg_addr,
        output i2c_rd_data,
        output i2c_avail_data,
        output i2c_avail_master
    );
endinterface

// File: rtl/mpu6050_burst_sequencer.sv
// Periodically reads NUM_BYTES MPU6050 registers (one start/read/stop each) and packs them into 3 signed axis words.
// Latency: sample_valid rises exactly 1 cycle after the final stop handshake of a burst.
// Backpressure: each register waits on master handshakes; a per-register timeout aborts the burst.
//
// Ports:
//   clk, reset (async, active-low)       clock shared with the I2C master
//   enable                               1 = periodic bursts; 0 = finish current burst, then idle
//   i2c (master modport)                 start/stop/reg_addr out, rd_data/avail_data/avail_master in
//   accel_x/y/z                          {byte0,byte1}, {byte2,byte3}, {byte4,byte5}, signed
//   sample_valid                         1-cycle pulse when accel_* update
//   busy                                 1 whenever the sequencer is not idle
//   timeout_err                          sticky until the next completed burst
module mpu6050_burst_sequencer #(
    parameter logic [7:0] BASE_REG       = 8'h3B,
    parameter int         NUM_BYTES      = 6,
    parameter int         PERIOD_CYCLES  = 50000,
    parameter int         TIMEOUT_CYCLES = 20000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    mpu6050_burst_sequencer_if.master i2c,
    output logic signed [15:0]        accel_x,
    output logic signed [15:0]        accel_y,
    output logic signed [15:0]        accel_z,
    output logic                      sample_valid,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    // One extra value of headroom: the counter may step once past the last
    // compare value on the cycle the timeout fires.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_DAT,
        STOP,
        DONE,
        ABORT
    } state_t;

    state_t                        state_q, state_d;
    logic [PW-1:0]                 period_q, period_d;
    logic [TW-1:0]                 to_cnt_q, to_cnt_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [7:0]                    addr_q, addr_d;
    logic [NUM_BYTES-1:0][7:0]     shadow_q, shadow_d;
    logic [15:0]                   accel_x_q, accel_x_d;
    logic [15:0]                   accel_y_q, accel_y_d;
    logic [15:0]                   accel_z_q, accel_z_d;
    logic                          sample_valid_q, sample_valid_d;
    logic                          timeout_err_q, timeout_err_d;

    // The master lives on a divided clock: both status levels are registered
    // once, and avail_data is only ever used as a rising-edge event so a
    // byte that stays valid for many cycles is captured exactly once.
    logic                          avail_data_q, avail_data_d;
    logic                          avail_data_prev_q, avail_data_prev_d;
    logic                          avail_master_q, avail_master_d;

    logic                          tick;
    logic                          data_rise;
    logic                          to_active;
    logic                          to_fire;

    always_comb begin
        avail_data_d      = i2c.i2c_avail_data;
        avail_data_prev_d = avail_data_q;
        avail_master_d    = i2c.i2c_avail_master;
    end

    assign data_rise = avail_data_q & ~avail_data_prev_q;

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        to_cnt_d       = to_cnt_q;
        idx_d          = idx_q;
        addr_d         = addr_q;
        shadow_d       = shadow_q;
        accel_x_d      = accel_x_q;
        accel_y_d      = accel_y_q;
        accel_z_d      = accel_z_q;
        sample_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;
        tick           = 1'b0;

        // Free-running period counter; it keeps counting during a burst so
        // the burst-to-burst spacing is fixed. Ticks seen while busy are lost.
        if (enable) begin
            if (period_q == PERIOD_LAST) begin
                period_d = '0;
                tick     = 1'b1;
            end else begin
                period_d = period_q + 1'b1;
            end
        end

        to_active = (state_q == WAIT_RDY) || (state_q == ISSUE) ||
                    (state_q == WAIT_DAT) || (state_q == STOP);
        to_fire   = to_active && (to_cnt_q == TIMEOUT_LAST);
        if (to_active) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    idx_d    = '0;
                    addr_d   = BASE_REG;
                    to_cnt_d = '0;
                    state_d  = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (avail_master_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Master going busy is the start acknowledge.
                if (!avail_master_q) begin
                    state_d = WAIT_DAT;
                end
            end
            WAIT_DAT: begin
                if (data_rise) begin
                    shadow_d[idx_q] = i2c.i2c_rd_data;
                    state_d         = STOP;
                end
            end
            STOP: begin
                if (avail_master_q) begin
                    if (idx_q == IDX_LAST) begin
                        // Publish all three axes in the same cycle so readers
                        // never see a mix of two bursts.
                        accel_x_d      = {shadow_q[0], shadow_q[1]};
                        accel_y_d      = {shadow_q[2], shadow_q[3]};
                        accel_z_d      = {shadow_q[4], shadow_q[5]};
                        sample_valid_d = 1'b1;
                        timeout_err_d  = 1'b0;
                        state_d        = DONE;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        addr_d   = BASE_REG + 8'(idx_d);
                        to_cnt_d = '0;
                        state_d  = WAIT_RDY;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ABORT: begin
                // Hold stop until the master is back to idle, then give up
                // on the partial burst.
                if (avail_master_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timeout overrides any transition taken this cycle; the partial
        // burst is discarded and the published axes stay as they were.
        if (to_fire) begin
            timeout_err_d  = 1'b1;
            sample_valid_d = 1'b0;
            accel_x_d      = accel_x_q;
            accel_y_d      = accel_y_q;
            accel_z_d      = accel_z_q;
            state_d        = (state_q == STOP) ? IDLE : ABORT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            period_q          <= '0;
            to_cnt_q          <= '0;
            idx_q             <= '0;
            addr_q            <= '0;
            shadow_q          <= '0;
            accel_x_q         <= '0;
            accel_y_q         <= '0;
            accel_z_q         <= '0;
            sample_valid_q    <= 1'b0;
            timeout_err_q     <= 1'b0;
            avail_data_q      <= 1'b0;
            avail_data_prev_q <= 1'b0;
            avail_master_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            period_q          <= period_d;
            to_cnt_q          <= to_cnt_d;
            idx_q             <= idx_d;
            addr_q            <= addr_d;
            shadow_q          <= shadow_d;
            accel_x_q         <= accel_x_d;
            accel_y_q         <= accel_y_d;
            accel_z_q         <= accel_z_d;
            sample_valid_q    <= sample_valid_d;
            timeout_err_q     <= timeout_err_d;
            avail_data_q      <= avail_data_d;
            avail_data_prev_q <= avail_data_prev_d;
            avail_master_q    <= avail_master_d;
        end
    end

    // Start and stop decode from mutually exclusive states, so they can
    // never be high together.
    assign i2c.i2c_start    = (state_q == ISSUE);
    assign i2c.i2c_stop     = (state_q == STOP) || (state_q == ABORT);
    assign i2c.i2c_reg_addr = addr_q;

    assign accel_x      = accel_x_q;
    assign accel_y      = accel_y_q;
    assign accel_z      = accel_z_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mpu6050_burst_sequencer.sv
// Bench for mpu6050_burst_sequencer with a behavioural I2C master model and an axis scoreboard.
// Short period/timeout parameters keep the run to a few thousand cycles.
// Master model answers each start after a fixed delay; data hold length and a hanging byte are configurable.
module tb_mpu6050_burst_sequencer;

    localparam int PERIOD = 600;
    localparam int TOUT   = 200;
    localparam int BOUND  = 3 * PERIOD;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic        sample_valid;
    logic        busy;
    logic        timeout_err;

    mpu6050_burst_sequencer_if bus ();

    mpu6050_burst_sequencer #(
        .BASE_REG       (8'h3B),
        .NUM_BYTES      (6),
        .PERIOD_CYCLES  (PERIOD),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .i2c          (bus.master),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- I2C master model ----------------
    logic [7:0] mem [0:5];
    int         skip_byte = -1;
    int         hold_len  = 4;
    int         m_st      = 0;
    int         m_cnt     = 0;
    int         hold_cnt  = 0;
    logic [7:0] m_byte    = 8'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st                 <= 0;
            m_cnt                <= 0;
            hold_cnt             <= 0;
            bus.i2c_avail_master <= 1'b1;
            bus.i2c_avail_data   <= 1'b0;
            bus.i2c_rd_data      <= 8'h00;
        end else begin
            if (hold_cnt > 0) begin
                hold_cnt <= hold_cnt - 1;
                if (hold_cnt == 1) bus.i2c_avail_data <= 1'b0;
            end
            case (m_st)
                0: if (bus.i2c_start) begin m_cnt <= 3; m_st <= 1; end
                1: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                   else begin
                       bus.i2c_avail_master <= 1'b0;
                       m_byte <= bus.i2c_reg_addr - 8'h3B;
                       m_cnt  <= 8;
                       m_st   <= 2;
                   end
                2: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                   else if (int'(m_byte) == skip_byte) m_st <= 3;
                   else if (bus.i2c_avail_data) begin
                       // previous byte still flagged: drop it so a fresh edge follows
                       bus.i2c_avail_data <= 1'b0;
                       hold_cnt <= 0;
                   end else begin
                       bus.i2c_rd_data    <= mem[m_byte];
                       bus.i2c_avail_data <= 1'b1;
                       hold_cnt <= hold_len;
                       m_st     <= 3;
                   end
                3: if (bus.i2c_stop) begin m_cnt <= 3; m_st <= 4; end
                4: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                   else begin bus.i2c_avail_master <= 1'b1; m_st <= 0; end
                default: m_st <= 0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [47:0] exp_q [$];
    int          cyc         = 0;
    int          exp_idx     = 0;
    int          st_cnt      = 0;
    int          sp_cnt      = 0;
    int          start_total = 0;
    int          sample_cnt  = 0;
    int          stop_to_cnt = 0;
    int          t_addr2     = 0;
    int          t_to        = 0;
    logic        prev_busy   = 1'b0;
    logic        prev_start  = 1'b0;
    logic        prev_stop   = 1'b0;
    logic        prev_to     = 1'b0;
    logic [7:0]  prev_addr   = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [47:0] e;
        if (reset) begin
            if (busy && !prev_busy) begin
                exp_idx = 0;
                st_cnt  = 0;
                sp_cnt  = 0;
            end
            if (bus.i2c_start && !prev_start) begin
                check("reg_addr", bus.i2c_reg_addr, 64'(8'h3B + exp_idx));
                exp_idx++;
                st_cnt++;
                start_total++;
            end
            if (bus.i2c_stop && !prev_stop) sp_cnt++;
            if (bus.i2c_start || bus.i2c_stop)
                check("start_stop_overlap", bus.i2c_start & bus.i2c_stop, 0);
            if (bus.i2c_stop && timeout_err) stop_to_cnt++;
            if (bus.i2c_reg_addr == 8'h3D && prev_addr != 8'h3D) t_addr2 = cyc;
            if (timeout_err && !prev_to) t_to = cyc;
            if (sample_valid) begin
                sample_cnt++;
                check("sv_after_stop", prev_stop, 1);
                check("starts_per_burst", st_cnt, 6);
                check("stops_per_burst", sp_cnt, 6);
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("accel_x", accel_x, e[47:32]);
                    check("accel_y", accel_y, e[31:16]);
                    check("accel_z", accel_z, e[15:0]);
                end
            end
        end
        prev_busy  = busy;
        prev_start = bus.i2c_start;
        prev_stop  = bus.i2c_stop;
        prev_to    = timeout_err;
        prev_addr  = bus.i2c_reg_addr;
    end

    // ---------------- helpers ----------------
    task automatic set_mem(input logic [47:0] v);
        for (int i = 0; i < 6; i++) mem[i] = v[47 - 8*i -: 8];
    endtask

    task automatic wait_samples(input int target, input string tag);
        int n = 0;
        while (sample_cnt < target && n < BOUND) begin @(negedge clk); n++; end
        check(tag, sample_cnt >= target, 1);
    endtask

    task automatic wait_addr(input logic [7:0] a, input string tag);
        int n = 0;
        while (!(busy && bus.i2c_reg_addr == a) && n < BOUND) begin @(negedge clk); n++; end
        check(tag, bus.i2c_reg_addr, a);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < BOUND) begin @(negedge clk); n++; end
        check(tag, busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_accel"}, {accel_x, accel_y, accel_z}, 0);
        check({tag, "_ctl"}, {sample_valid, busy, timeout_err, bus.i2c_start, bus.i2c_stop}, 0);
        check({tag, "_addr"}, bus.i2c_reg_addr, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int s0;
        logic [47:0] v;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // basic burst
        v = 48'h01_02_03_04_05_06;
        set_mem(v);
        exp_q.push_back(v);
        enable = 1'b1;
        wait_samples(1, "burst1_done");

        // long avail_data level; negative x axis
        v = 48'hFF_80_03_04_05_06;
        set_mem(v);
        hold_len = 40;
        exp_q.push_back(v);
        wait_samples(2, "hold40_done");
        check("hold40_x_signed", 64'($signed(accel_x)), 64'(-128));
        hold_len = 4;

        // byte 2 never arrives -> timeout
        skip_byte = 2;
        s0 = stop_to_cnt;
        n  = 0;
        while (!timeout_err && n < BOUND) begin @(negedge clk); n++; end
        check("timeout_set", timeout_err, 1);
        wait_idle("timeout_idle");
        check("timeout_latency", t_to - t_addr2, TOUT);
        check("timeout_stop", stop_to_cnt > s0, 1);
        check("timeout_keep_accel", {accel_x, accel_y, accel_z}, 48'hFF80_0304_0506);
        check("timeout_no_sample", sample_cnt, 2);

        // recovery burst clears the sticky error
        skip_byte = -1;
        v = 48'h11_12_13_14_15_16;
        set_mem(v);
        exp_q.push_back(v);
        wait_samples(3, "recover_done");
        check("timeout_cleared", timeout_err, 0);

        // reset during WAIT_DAT of byte 4
        wait_addr(8'h3F, "reach_byte4");
        n = 0;
        while (!bus.i2c_start && n < 200) begin @(negedge clk); n++; end
        while (bus.i2c_start && n < 400) begin @(negedge clk); n++; end
        check("reach_wait_dat", busy & ~bus.i2c_start & ~bus.i2c_stop, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("midburst_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v = 48'h21_22_23_24_25_26;
        set_mem(v);
        exp_q.push_back(v);
        n = 0;
        while (!busy && n < BOUND) begin @(negedge clk); n++; end
        check("after_reset_first_addr", bus.i2c_reg_addr, 8'h3B);
        wait_samples(4, "after_reset_done");

        // enable drops during byte 3: burst completes, then silence
        v = 48'h31_32_33_34_35_36;
        set_mem(v);
        exp_q.push_back(v);
        wait_addr(8'h3E, "reach_byte3");
        enable = 1'b0;
        wait_samples(5, "disable_done");
        wait_idle("disable_idle");
        s0 = start_total;
        repeat (3 * PERIOD) @(negedge clk);
        check("disabled_no_start", start_total, s0);
        check("disabled_no_sample", sample_cnt, 5);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
